// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one 32-bit ALU between NUM_REQ clients of the multi-cycle core
// (PC increment, branch target, execute, ...). A round-robin arbiter accepts
// one request at a time, drives the ALU from registered operand flops, waits
// ALU_LAT cycles for the result to settle, then presents the registered
// result to the requester that owns the operation until it is accepted.
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   req_valid_i   per-requester request valid
//   req_ready_o   one-hot grant (only in IDLE), handshake = valid & ready
//   req_sel_i     4-bit ALU op code per requester, slice i = requester i
//   req_op1_i     32-bit operand 1 per requester
//   req_op2_i     32-bit operand 2 per requester
//   rsp_valid_o   one-hot result valid towards the owning requester
//   rsp_ready_i   per-requester result accept (only the owner's bit counts)
//   rsp_result_o  registered ALU result, shared by all requesters
//   alu_sel_o     op code towards the ALU
//   alu_op1_o     operand 1 towards the ALU
//   alu_op2_o     operand 2 towards the ALU
//   alu_result_i  combinational result coming back from the ALU
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ALU_LAT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [4*NUM_REQ-1:0]  req_sel_i,
   input  logic [32*NUM_REQ-1:0] req_op1_i,
   input  logic [32*NUM_REQ-1:0] req_op2_i,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   input  logic [NUM_REQ-1:0]    rsp_ready_i,
   output logic [31:0]           rsp_result_o,
   output logic [3:0]            alu_sel_o,
   output logic [31:0]           alu_op1_o,
   output logic [31:0]           alu_op2_o,
   input  logic [31:0]           alu_result_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e            state_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  owner_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [3:0]        alu_sel_q;
   logic [31:0]       alu_op1_q;
   logic [31:0]       alu_op2_q;
   logic [31:0]       rsp_result_q;

   logic [PTR_W-1:0]  winner;
   logic [PTR_W-1:0]  ptr_d;
   logic              found;
   logic              grant;
   logic [3:0]        win_sel;
   logic [31:0]       win_op1;
   logic [31:0]       win_op2;

   // Round-robin search: the first valid requester at or after the pointer,
   // wrapping modulo NUM_REQ (works for non power-of-two counts too).
   always_comb begin
      int idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!found && req_valid_i[idx[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[PTR_W-1:0];
         end
      end
   end

   // Operand mux for the winning requester and the pointer that follows it.
   always_comb begin
      int w;
      w       = int'(winner);
      win_sel = req_sel_i[w*4 +: 4];
      win_op1 = req_op1_i[w*32 +: 32];
      win_op2 = req_op2_i[w*32 +: 32];
      if (winner == PTR_W'(NUM_REQ - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = winner + 1'b1;
      end
   end

   // Grants are only offered in IDLE and never while reset is asserted, so
   // a request seen during reset cannot complete a handshake.
   assign grant       = (state_q == IDLE) && found && !rst_i;
   assign req_ready_o = grant ? (NUM_REQ'(1) << winner) : '0;

   // Response valid decodes purely from state so it never depends on
   // rsp_ready_i within the same cycle.
   assign rsp_valid_o = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;

   assign rsp_result_o = rsp_result_q;
   assign alu_sel_o    = alu_sel_q;
   assign alu_op1_o    = alu_op1_q;
   assign alu_op2_o    = alu_op2_q;

   // Control FSM. The ALU operand flops only load on a grant, so they keep
   // their last values through EXEC, RESP and the following IDLE period.
   // The counter gives the ALU ALU_LAT cycles to settle before sampling.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         cnt_q        <= '0;
         alu_sel_q    <= 4'd0;
         alu_op1_q    <= '0;
         alu_op2_q    <= '0;
         rsp_result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant) begin
                  alu_sel_q <= win_sel;
                  alu_op1_q <= win_op1;
                  alu_op2_q <= win_op2;
                  owner_q   <= winner;
                  ptr_q     <= ptr_d;
                  cnt_q     <= CNT_W'(ALU_LAT - 1);
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  rsp_result_q <= alu_result_i;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i[owner_q]) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Two arbiters (ALU_LAT=1 and ALU_LAT=3) are driven by the same requesters.
// Each has its own stand-in ALU and its own transaction-level model of the
// expected grants, operand drive and responses, checked every cycle.
// Directed sequences pin a few literal values on top of the model.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  reqValid = 2'b11;
   logic [7:0]  reqSel = '0;
   logic [63:0] reqOp1 = '0;
   logic [63:0] reqOp2 = '0;
   logic [1:0]  rspReady = '0;

   logic [1:0][1:0]  reqReady;
   logic [1:0][1:0]  rspValid;
   logic [1:0][31:0] rspResult;
   logic [1:0][3:0]  aluSel;
   logic [1:0][31:0] aluOp1;
   logic [1:0][31:0] aluOp2;
   logic [1:0][31:0] aluResult;

   int checks = 0;
   int errors = 0;

   // Stand-in for the shared ALU; unknown op codes give 0.
   function automatic logic [31:0] aluRef(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return 32'd0;
      endcase
   endfunction

   assign aluResult[0] = aluRef(aluSel[0], aluOp1[0], aluOp2[0]);
   assign aluResult[1] = aluRef(aluSel[1], aluOp1[1], aluOp2[1]);

   alu_share_arbiter #(.NUM_REQ(2), .ALU_LAT(1)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(reqValid), .req_ready_o(reqReady[0]),
      .req_sel_i(reqSel), .req_op1_i(reqOp1), .req_op2_i(reqOp2),
      .rsp_valid_o(rspValid[0]), .rsp_ready_i(rspReady), .rsp_result_o(rspResult[0]),
      .alu_sel_o(aluSel[0]), .alu_op1_o(aluOp1[0]), .alu_op2_o(aluOp2[0]),
      .alu_result_i(aluResult[0])
   );

   alu_share_arbiter #(.NUM_REQ(2), .ALU_LAT(3)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(reqValid), .req_ready_o(reqReady[1]),
      .req_sel_i(reqSel), .req_op1_i(reqOp1), .req_op2_i(reqOp2),
      .rsp_valid_o(rspValid[1]), .rsp_ready_i(rspReady), .rsp_result_o(rspResult[1]),
      .alu_sel_o(aluSel[1]), .alu_op1_o(aluOp1[1]), .alu_op2_o(aluOp2[1]),
      .alu_result_i(aluResult[1])
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model per instance: an operation is either waiting
   // to be computed (cyclesLeft > 0), being presented, or there is none.
   int          latency[2] = '{1, 3};
   int          cyclesLeft[2] = '{0, 0};
   bit          presenting[2] = '{0, 0};
   int          rrNext[2] = '{0, 0};
   int          owner[2] = '{0, 0};
   logic [3:0]  expSel[2] = '{4'd0, 4'd0};
   logic [31:0] expOp1[2] = '{32'd0, 32'd0};
   logic [31:0] expOp2[2] = '{32'd0, 32'd0};
   logic [31:0] expRes[2] = '{32'd0, 32'd0};

   bit          logOn = 1'b0;
   int          grantLog[$];
   logic [31:0] lastResp1 = '0;

   // Compare every instance against its model in mid-cycle, then advance
   // the model with the inputs that the coming rising edge will sample.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int w;
         logic [1:0] expReady;
         logic [1:0] expRspValid;
         w = -1;
         if (!rst && cyclesLeft[k] == 0 && !presenting[k]) begin
            for (int i = 0; i < 2; i++) begin
               int idx;
               idx = (rrNext[k] + i) % 2;
               if (w < 0 && reqValid[idx]) w = idx;
            end
         end
         expReady    = (w >= 0) ? 2'(1 << w) : 2'b00;
         expRspValid = presenting[k] ? 2'(1 << owner[k]) : 2'b00;
         checkOutput($sformatf("req_ready[%0d]", k), 32'(reqReady[k]), 32'(expReady));
         checkOutput($sformatf("rsp_valid[%0d]", k), 32'(rspValid[k]), 32'(expRspValid));
         checkOutput($sformatf("rsp_result[%0d]", k), rspResult[k], expRes[k]);
         checkOutput($sformatf("alu_sel[%0d]", k), 32'(aluSel[k]), 32'(expSel[k]));
         checkOutput($sformatf("alu_op1[%0d]", k), aluOp1[k], expOp1[k]);
         checkOutput($sformatf("alu_op2[%0d]", k), aluOp2[k], expOp2[k]);

         if (k == 0 && logOn) begin
            if (w >= 0) grantLog.push_back(w);
            if (rspValid[0][1] && rspReady[1]) lastResp1 = rspResult[0];
         end

         if (rst) begin
            cyclesLeft[k] = 0; presenting[k] = 0; rrNext[k] = 0; owner[k] = 0;
            expSel[k] = '0; expOp1[k] = '0; expOp2[k] = '0; expRes[k] = '0;
         end else if (w >= 0) begin
            owner[k]      = w;
            rrNext[k]     = (w + 1) % 2;
            expSel[k]     = reqSel[w*4 +: 4];
            expOp1[k]     = reqOp1[w*32 +: 32];
            expOp2[k]     = reqOp2[w*32 +: 32];
            cyclesLeft[k] = latency[k];
         end else if (cyclesLeft[k] > 0) begin
            cyclesLeft[k]--;
            if (cyclesLeft[k] == 0) begin
               expRes[k]     = aluRef(expSel[k], expOp1[k], expOp2[k]);
               presenting[k] = 1'b1;
            end
         end else if (presenting[k] && rspReady[owner[k]]) begin
            presenting[k] = 1'b0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rr,
                                input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] b1);
      reqValid = v;
      rspReady = rr;
      reqSel   = {s1, s0};
      reqOp1   = {a1, a0};
      reqOp2   = {b1, b0};
   endtask

   task automatic doReset();
      applyStimulus(2'b00, 2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      // Reset with every requester asking: nothing may be granted.
      cyc();
      @(negedge clk);
      checkOutput("t1 ready during reset", 32'(reqReady[0]), 32'd0);
      checkOutput("t1 rsp_valid during reset", 32'(rspValid[0]), 32'd0);
      checkOutput("t1 alu_op1 during reset", aluOp1[0], 32'd0);
      cyc();
      doReset();

      // Single ADD on requester 0, result two cycles after the handshake.
      applyStimulus(2'b01, 2'b00, ALU_ADD, 32'd5, 32'd7, 4'd0, 0, 0);
      @(negedge clk);
      checkOutput("t2 grant", 32'(reqReady[0]), 32'h1);
      cyc();
      reqValid = 2'b00;
      @(negedge clk);
      checkOutput("t2 no early rsp", 32'(rspValid[0]), 32'h0);
      cyc();
      @(negedge clk);
      checkOutput("t2 rsp_valid", 32'(rspValid[0]), 32'h1);
      checkOutput("t2 result", rspResult[0], 32'd12);
      rspReady = 2'b01;
      repeat (6) cyc();

      // Round robin with both requesters always asking.
      doReset();
      applyStimulus(2'b11, 2'b11, ALU_ADD, 32'd1, 32'd2, ALU_SUB, 32'd3, 32'd5);
      grantLog.delete();
      logOn = 1'b1;
      repeat (14) cyc();
      logOn = 1'b0;
      checkOutput("t3 grant count>=4", 32'(grantLog.size() >= 4), 32'd1);
      if (grantLog.size() >= 4) begin
         checkOutput("t3 grant0", 32'(grantLog[0]), 32'd0);
         checkOutput("t3 grant1", 32'(grantLog[1]), 32'd1);
         checkOutput("t3 grant2", 32'(grantLog[2]), 32'd0);
         checkOutput("t3 grant3", 32'(grantLog[3]), 32'd1);
      end
      checkOutput("t3 sub result", lastResp1, 32'hFFFFFFFE);

      // Response backpressure: result held, no grants while presenting.
      doReset();
      applyStimulus(2'b01, 2'b00, ALU_ADD, 32'd100, 32'd23, ALU_XOR, 32'hF0, 32'h0F);
      @(negedge clk);
      checkOutput("t4 grant", 32'(reqReady[0]), 32'h1);
      cyc();
      reqValid = 2'b11;
      @(negedge clk);
      checkOutput("t4 no grant in exec", 32'(reqReady[0]), 32'h0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("t4 rsp_valid held", 32'(rspValid[0]), 32'h1);
         checkOutput("t4 result held", rspResult[0], 32'd123);
         checkOutput("t4 no grant in resp", 32'(reqReady[0]), 32'h0);
         cyc();
      end
      rspReady = 2'b01;
      @(negedge clk);
      checkOutput("t4 no grant on accept", 32'(reqReady[0]), 32'h0);
      cyc();
      @(negedge clk);
      checkOutput("t4 next grant rr", 32'(reqReady[0]), 32'h2);
      cyc();

      // Longer ALU latency on the second instance.
      doReset();
      applyStimulus(2'b10, 2'b00, 4'd0, 0, 0, ALU_SRA, 32'h80000000, 32'd4);
      @(negedge clk);
      checkOutput("t5 grant", 32'(reqReady[1]), 32'h2);
      cyc();
      reqValid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t5 sel stable", 32'(aluSel[1]), 32'(ALU_SRA));
         checkOutput("t5 op1 stable", aluOp1[1], 32'h80000000);
         checkOutput("t5 op2 stable", aluOp2[1], 32'd4);
         checkOutput("t5 no early rsp", 32'(rspValid[1]), 32'h0);
         cyc();
      end
      @(negedge clk);
      checkOutput("t5 rsp_valid", 32'(rspValid[1]), 32'h2);
      checkOutput("t5 result", rspResult[1], 32'hF8000000);
      rspReady = 2'b10;
      cyc();

      // Reset while executing: no response, pointer back to requester 0.
      doReset();
      applyStimulus(2'b11, 2'b11, ALU_ADD, 32'd1, 32'd1, ALU_SUB, 32'd9, 32'd4);
      @(negedge clk);
      checkOutput("t6 first grant", 32'(reqReady[0]), 32'h1);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6 no grant in reset", 32'(reqReady[0]), 32'h0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6 no rsp after abort", 32'(rspValid[0]), 32'h0);
      checkOutput("t6 grant back to 0", 32'(reqReady[0]), 32'h1);
      cyc();

      // Random traffic, including undefined op codes and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         reqValid = 2'($urandom_range(0, 3));
         rspReady = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         reqSel   = 8'($urandom);
         reqOp1   = {$urandom, $urandom};
         reqOp2   = {32'($urandom_range(0, 40)), $urandom};
         rst      = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
